// File: rtl/uart_rx_frame_if.sv
// Bus bundle between the RX pin synchronizer / data consumer and uart_rx_frame.
// The master side drives the serial line and frame options; the slave side is the receiver.
interface uart_rx_frame_if #(
   parameter int Data_Width = 8
);
   logic                  RX_IN;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [Data_Width-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_ERR;
   logic                  STP_ERR;
   logic                  Busy;

   modport master (
      output RX_IN, PAR_EN, PAR_TYP,
      input  P_DATA, Data_Valid, PAR_ERR, STP_ERR, Busy
   );

   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP,
      output P_DATA, Data_Valid, PAR_ERR, STP_ERR, Busy
   );
endinterface

// File: rtl/uart_rx_frame.sv
// UART frame receiver: oversampled start detect, LSB-first data shift, optional
// parity check and stop check, with one-cycle valid/error pulses per completed frame.
module uart_rx_frame #(
   parameter int Data_Width = 8,
   parameter int PRESCALE   = 8
) (
   input logic             CLK,
   input logic             RST,
   uart_rx_frame_if.slave  bus
);

   localparam int HALF = PRESCALE / 2;
   localparam int EW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BW   = $clog2(Data_Width + 1);

   localparam logic [EW-1:0] SAMP0_TICK = EW'(HALF - 1);
   localparam logic [EW-1:0] SAMP1_TICK = EW'(HALF);
   localparam logic [EW-1:0] DECIDE_TICK = EW'(HALF + 1);
   localparam logic [EW-1:0] LAST_TICK  = EW'(PRESCALE - 1);
   localparam logic [BW-1:0] LAST_BIT   = BW'(Data_Width);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [Data_Width-1:0] shift_q, shift_d;
   logic [1:0]            samp_q, samp_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  par_bad_q, par_bad_d;
   logic [Data_Width-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic                  maj_bit;
   logic                  edge_wrap;
   logic                  decide;
   logic [EW-1:0]         edge_next;
   logic                  exp_parity;

   // Two earlier samples are stored; the third is the live line at the decision tick.
   assign maj_bit    = (samp_q[0] & samp_q[1]) | (samp_q[0] & bus.RX_IN) | (samp_q[1] & bus.RX_IN);
   assign edge_wrap  = (edge_cnt_q == LAST_TICK);
   assign decide     = (edge_cnt_q == DECIDE_TICK);
   assign edge_next  = edge_wrap ? '0 : edge_cnt_q + 1'b1;
   assign exp_parity = par_typ_q ? ~^shift_q : ^shift_q;

   always_comb begin
      state_d      = state_q;
      edge_cnt_d   = edge_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      samp_d       = samp_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      par_bad_d    = par_bad_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;

      if (edge_cnt_q == SAMP0_TICK) samp_d[0] = bus.RX_IN;
      if (edge_cnt_q == SAMP1_TICK) samp_d[1] = bus.RX_IN;

      case (state_q)
         S_IDLE: begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
            // The cycle that sees the falling edge counts as tick 0 of the start bit.
            if (!bus.RX_IN) begin
               state_d    = S_START;
               edge_cnt_d = EW'(1);
               par_en_d   = bus.PAR_EN;
               par_typ_d  = bus.PAR_TYP;
               par_bad_d  = 1'b0;
            end
         end
         S_START: begin
            edge_cnt_d = edge_next;
            if (decide && maj_bit) begin
               state_d    = S_IDLE;
               edge_cnt_d = '0;
            end else if (edge_wrap) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            edge_cnt_d = edge_next;
            if (decide) begin
               shift_d   = {maj_bit, shift_q[Data_Width-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (edge_wrap && (bit_cnt_q == LAST_BIT)) begin
               state_d   = par_en_q ? S_PARITY : S_STOP;
               bit_cnt_d = '0;
            end
         end
         S_PARITY: begin
            edge_cnt_d = edge_next;
            if (decide) par_bad_d = (maj_bit != exp_parity);
            if (edge_wrap) state_d = S_STOP;
         end
         S_STOP: begin
            edge_cnt_d = edge_next;
            // Leave at the decision tick so the next start edge can be caught early.
            if (decide) begin
               state_d    = S_IDLE;
               edge_cnt_d = '0;
               if (!maj_bit) begin
                  stp_err_d = 1'b1;
               end else if (par_bad_q) begin
                  par_err_d = 1'b1;
               end else begin
                  p_data_d     = shift_q;
                  data_valid_d = 1'b1;
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q      <= S_IDLE;
         edge_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         samp_q       <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_bad_q    <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         edge_cnt_q   <= edge_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         samp_q       <= samp_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         par_bad_q    <= par_bad_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign bus.P_DATA     = p_data_q;
   assign bus.Data_Valid = data_valid_q;
   assign bus.PAR_ERR    = par_err_q;
   assign bus.STP_ERR    = stp_err_q;
   assign bus.Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: each scenario task sends hand-built frames and
// checks pulse counts, pulse timing and P_DATA against hand-computed values.
module tb_uart_rx_frame;

   localparam int PRESCALE = 8;

   logic clk;
   logic rst_n;
   int   cyc;
   int   stop_cyc;
   int   dv_cnt, pe_cnt, se_cnt;
   int   dv_cyc;
   int   assert_cnt;
   int   fail_cnt;

   uart_rx_frame_if #(.Data_Width(8)) bus ();

   uart_rx_frame #(.Data_Width(8), .PRESCALE(PRESCALE)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor sampled mid-cycle; a pulse longer than one clock counts twice.
   always @(negedge clk) begin
      if (bus.Data_Valid === 1'b1) begin
         dv_cnt = dv_cnt + 1;
         dv_cyc = cyc;
      end
      if (bus.PAR_ERR === 1'b1) pe_cnt = pe_cnt + 1;
      if (bus.STP_ERR === 1'b1) se_cnt = se_cnt + 1;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic noisy);
      for (int i = 0; i < PRESCALE; i++) begin
         bus.RX_IN = (noisy && i == 4) ? ~b : b;
         @(posedge clk);
         #1;
      end
   endtask

   // Stop level is held through the decision tick, then the line idles high.
   task automatic send_frame(input logic [7:0] data, input logic has_par, input logic par_bit,
                             input logic stop_bit, input int noise_idx);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i], i == noise_idx);
      if (has_par) send_bit(par_bit, 1'b0);
      stop_cyc = cyc;
      for (int i = 0; i < PRESCALE; i++) begin
         bus.RX_IN = (i < 6) ? stop_bit : 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus.RX_IN   = 1'b1;
      bus.PAR_EN  = 1'b0;
      bus.PAR_TYP = 1'b0;
      wait_cycles(3);
      assert_cnt++;
      if (bus.P_DATA !== 8'h00) begin
         fail_cnt++;
         $display("[TB] FAIL reset_p_data: got %h want 00", bus.P_DATA);
      end
      assert_cnt++;
      if ({bus.Data_Valid, bus.PAR_ERR, bus.STP_ERR, bus.Busy} !== 4'b0000) begin
         fail_cnt++;
         $display("[TB] FAIL reset_flags: got %b want 0000",
                  {bus.Data_Valid, bus.PAR_ERR, bus.STP_ERR, bus.Busy});
      end
      rst_n = 1'b1;
      wait_cycles(2);
   endtask

   task automatic test_no_parity();
      int dv0, pe0, se0;
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      bus.PAR_EN = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
      wait_cycles(2);
      assert_cnt++;
      if ({dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0} !== {32'd1, 32'd0, 32'd0}) begin
         fail_cnt++;
         $display("[TB] FAIL nopar_counts: got dv=%0d pe=%0d se=%0d want 1 0 0",
                  dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
      end
      assert_cnt++;
      if (bus.P_DATA !== 8'hA5) begin
         fail_cnt++;
         $display("[TB] FAIL nopar_data: got %h want a5", bus.P_DATA);
      end
      assert_cnt++;
      if (dv_cyc - stop_cyc !== 6) begin
         fail_cnt++;
         $display("[TB] FAIL nopar_latency: got %0d want 6", dv_cyc - stop_cyc);
      end
   endtask

   task automatic test_even_parity();
      int dv0, pe0, se0;
      bus.PAR_EN  = 1'b1;
      bus.PAR_TYP = 1'b0;
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
      wait_cycles(2);
      assert_cnt++;
      if ({dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0} !== {32'd1, 32'd0, 32'd0}) begin
         fail_cnt++;
         $display("[TB] FAIL even_ok_counts: got dv=%0d pe=%0d se=%0d want 1 0 0",
                  dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
      end
      assert_cnt++;
      if (bus.P_DATA !== 8'h3C) begin
         fail_cnt++;
         $display("[TB] FAIL even_ok_data: got %h want 3c", bus.P_DATA);
      end
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(8'h3D, 1'b1, 1'b0, 1'b1, -1);
      wait_cycles(2);
      assert_cnt++;
      if ({dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0} !== {32'd0, 32'd1, 32'd0}) begin
         fail_cnt++;
         $display("[TB] FAIL even_bad_counts: got dv=%0d pe=%0d se=%0d want 0 1 0",
                  dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
      end
      assert_cnt++;
      if (bus.P_DATA !== 8'h3C) begin
         fail_cnt++;
         $display("[TB] FAIL even_bad_hold: got %h want 3c", bus.P_DATA);
      end
   endtask

   task automatic test_odd_parity();
      int dv0, pe0, se0;
      bus.PAR_EN  = 1'b1;
      bus.PAR_TYP = 1'b1;
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(8'h01, 1'b1, 1'b0, 1'b1, -1);
      wait_cycles(2);
      assert_cnt++;
      if ({dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0} !== {32'd1, 32'd0, 32'd0}) begin
         fail_cnt++;
         $display("[TB] FAIL odd_ok_counts: got dv=%0d pe=%0d se=%0d want 1 0 0",
                  dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
      end
      assert_cnt++;
      if (bus.P_DATA !== 8'h01) begin
         fail_cnt++;
         $display("[TB] FAIL odd_ok_data: got %h want 01", bus.P_DATA);
      end
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, -1);
      wait_cycles(2);
      assert_cnt++;
      if ({dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0} !== {32'd0, 32'd0, 32'd1}) begin
         fail_cnt++;
         $display("[TB] FAIL odd_stop_counts: got dv=%0d pe=%0d se=%0d want 0 0 1",
                  dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
      end
      // Bad parity and bad stop together: stop error wins.
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(8'h02, 1'b1, 1'b1, 1'b0, -1);
      wait_cycles(2);
      assert_cnt++;
      if ({dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0} !== {32'd0, 32'd0, 32'd1}) begin
         fail_cnt++;
         $display("[TB] FAIL stop_priority_counts: got dv=%0d pe=%0d se=%0d want 0 0 1",
                  dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
      end
      assert_cnt++;
      if (bus.P_DATA !== 8'h01) begin
         fail_cnt++;
         $display("[TB] FAIL stop_err_hold: got %h want 01", bus.P_DATA);
      end
   endtask

   task automatic test_glitch();
      int dv0, pe0, se0;
      bus.PAR_EN = 1'b0;
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      bus.RX_IN = 1'b0;
      wait_cycles(3);
      assert_cnt++;
      if (bus.Busy !== 1'b1) begin
         fail_cnt++;
         $display("[TB] FAIL glitch_busy_high: got %b want 1", bus.Busy);
      end
      bus.RX_IN = 1'b1;
      wait_cycles(3);
      assert_cnt++;
      if (bus.Busy !== 1'b0) begin
         fail_cnt++;
         $display("[TB] FAIL glitch_abort_tick5: got busy=%b want 0", bus.Busy);
      end
      wait_cycles(12);
      assert_cnt++;
      if ({dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0} !== {32'd0, 32'd0, 32'd0}) begin
         fail_cnt++;
         $display("[TB] FAIL glitch_counts: got dv=%0d pe=%0d se=%0d want 0 0 0",
                  dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
      end
   endtask

   task automatic test_back_to_back();
      int   dv0, pe0, se0;
      logic [7:0] first_data;
      bus.PAR_EN = 1'b0;
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, 2);
      first_data = bus.P_DATA;
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 7);
      wait_cycles(2);
      assert_cnt++;
      if (first_data !== 8'h55) begin
         fail_cnt++;
         $display("[TB] FAIL b2b_first_data: got %h want 55", first_data);
      end
      assert_cnt++;
      if (bus.P_DATA !== 8'hFF) begin
         fail_cnt++;
         $display("[TB] FAIL b2b_second_data: got %h want ff", bus.P_DATA);
      end
      assert_cnt++;
      if ({dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0} !== {32'd2, 32'd0, 32'd0}) begin
         fail_cnt++;
         $display("[TB] FAIL b2b_counts: got dv=%0d pe=%0d se=%0d want 2 0 0",
                  dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int dv0, pe0, se0;
      bus.PAR_EN = 1'b0;
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      assert_cnt++;
      if (bus.Busy !== 1'b1) begin
         fail_cnt++;
         $display("[TB] FAIL midreset_busy_before: got %b want 1", bus.Busy);
      end
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      rst_n = 1'b0;
      wait_cycles(1);
      assert_cnt++;
      if ({bus.P_DATA, bus.Data_Valid, bus.PAR_ERR, bus.STP_ERR, bus.Busy} !== 12'h000) begin
         fail_cnt++;
         $display("[TB] FAIL midreset_outputs: got data=%h flags=%b want 00 0000", bus.P_DATA,
                  {bus.Data_Valid, bus.PAR_ERR, bus.STP_ERR, bus.Busy});
      end
      rst_n     = 1'b1;
      bus.RX_IN = 1'b1;
      wait_cycles(40);
      assert_cnt++;
      if ({dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0, 31'd0, bus.Busy} !==
          {32'd0, 32'd0, 32'd0, 32'd0}) begin
         fail_cnt++;
         $display("[TB] FAIL midreset_quiet: got dv=%0d pe=%0d se=%0d busy=%b want 0 0 0 0",
                  dv_cnt - dv0, pe_cnt - pe0, se_cnt - se0, bus.Busy);
      end
      send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1);
      wait_cycles(2);
      assert_cnt++;
      if (bus.P_DATA !== 8'h96) begin
         fail_cnt++;
         $display("[TB] FAIL midreset_recover: got %h want 96", bus.P_DATA);
      end
   endtask

   initial begin
      cyc        = 0;
      dv_cnt     = 0;
      pe_cnt     = 0;
      se_cnt     = 0;
      dv_cyc     = 0;
      stop_cyc   = 0;
      assert_cnt = 0;
      fail_cnt   = 0;
      test_reset();
      test_no_parity();
      test_even_parity();
      test_odd_parity();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
